// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver. It synchronizes and filters the PS/2 pins, deframes 11-bit frames,
// checks odd parity and the stop bit, and decodes F0/E0 prefixes into key events.
// A one-cycle flap pulse fires on an unprefixed space-bar make code (0x29).
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       key_event,
  output logic       key_break,
  output logic       key_extended,
  output logic       flap,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
  localparam logic [TmoW-1:0]  TmoMax  = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeSpace = 8'h29;

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  // Synchronizer stages, both idle-high
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;

  // Clock glitch filter
  logic             clk_filt_q, clk_filt_d;
  logic             clk_prev_q, clk_prev_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;
  logic             data_bit;

  // Deframer
  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            brk_flag_q, brk_flag_d;
  logic            ext_flag_q, ext_flag_d;

  // Registered outputs
  logic [7:0] scan_code_q, scan_code_d;
  logic       scan_valid_q, scan_valid_d;
  logic       key_event_q, key_event_d;
  logic       key_break_q, key_break_d;
  logic       key_ext_q, key_ext_d;
  logic       flap_q, flap_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;

  // Two-stage synchronizers on both pins
  always_comb begin
    clk_s1_d = ps2_clock;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_cnt_d = '0;
    clk_filt_d = clk_filt_q;
    clk_prev_d = clk_filt_q;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FiltMax) begin
        clk_filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign fall     = clk_prev_q & ~clk_filt_q;
  assign data_bit = dat_s2_q;

  // Frame FSM, frame check and prefix decode
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    brk_flag_d   = brk_flag_q;
    ext_flag_d   = ext_flag_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    key_event_d  = 1'b0;
    key_break_d  = 1'b0;
    key_ext_d    = 1'b0;
    flap_d       = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_cnt_d = '0;
        if (fall && !data_bit) begin
          state_d   = StRecv;
          bit_cnt_d = 4'd1;
        end
      end
      StRecv: begin
        if (fall) begin
          // A fall in the same cycle as the timeout threshold still counts as a bit
          tmo_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shift_d = {data_bit, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            par_d = data_bit;
          end else begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            if (^{shift_q, par_q} == 1'b0) begin
              parity_err_d = 1'b1;
              brk_flag_d   = 1'b0;
              ext_flag_d   = 1'b0;
            end else if (!data_bit) begin
              frame_err_d = 1'b1;
              brk_flag_d  = 1'b0;
              ext_flag_d  = 1'b0;
            end else begin
              scan_code_d  = shift_q;
              scan_valid_d = 1'b1;
              if (shift_q == CodeBreak) begin
                brk_flag_d = 1'b1;
              end else if (shift_q == CodeExt) begin
                ext_flag_d = 1'b1;
              end else begin
                key_event_d = 1'b1;
                key_break_d = brk_flag_q;
                key_ext_d   = ext_flag_q;
                flap_d      = (shift_q == CodeSpace) && !brk_flag_q && !ext_flag_q;
                brk_flag_d  = 1'b0;
                ext_flag_d  = 1'b0;
              end
            end
          end
        end else if (tmo_cnt_q == TmoMax) begin
          frame_err_d = 1'b1;
          brk_flag_d  = 1'b0;
          ext_flag_d  = 1'b0;
          state_d     = StIdle;
          bit_cnt_d   = '0;
          tmo_cnt_d   = '0;
          shift_d     = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clk_filt_q   <= 1'b1;
      clk_prev_q   <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      brk_flag_q   <= 1'b0;
      ext_flag_q   <= 1'b0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      key_event_q  <= 1'b0;
      key_break_q  <= 1'b0;
      key_ext_q    <= 1'b0;
      flap_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      clk_filt_q   <= clk_filt_d;
      clk_prev_q   <= clk_prev_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      brk_flag_q   <= brk_flag_d;
      ext_flag_q   <= ext_flag_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      key_event_q  <= key_event_d;
      key_break_q  <= key_break_d;
      key_ext_q    <= key_ext_d;
      flap_q       <= flap_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scan_code    = scan_code_q;
  assign scan_valid   = scan_valid_q;
  assign key_event    = key_event_q;
  assign key_break    = key_break_q;
  assign key_extended = key_ext_q;
  assign flap         = flap_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q == StRecv);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed PS/2 frames, an event-queue model of the expected
// decoder output, and a per-cycle compare process.
module tb_ps2_scancode_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 500;
  localparam int unsigned HALF = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, key_event, key_break, key_extended, flap;
  logic       parity_err, frame_err, busy;

  ps2_scancode_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clock   (ps2_clock),
    .ps2_data    (ps2_data),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .key_event   (key_event),
    .key_break   (key_break),
    .key_extended(key_extended),
    .flap        (flap),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // flags = {scan_valid, key_event, key_break, key_extended, flap, parity_err, frame_err}
  typedef struct packed {
    logic [6:0] flags;
    logic [7:0] code;
  } ev_t;

  ev_t        exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_code;
  logic       brk_m, ext_m;
  logic [6:0] cap;
  logic [7:0] cap_code;
  int         cap_cyc;
  int         ev_cnt = 0;
  int         last_fall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Model: what a good byte must produce given the current prefix flags
  task automatic expect_good(input logic [7:0] c);
    ev_t e;
    e.code = c;
    if (c == 8'hF0) begin
      e.flags = 7'b1000000;
      brk_m = 1'b1;
    end else if (c == 8'hE0) begin
      e.flags = 7'b1000000;
      ext_m = 1'b1;
    end else begin
      e.flags = {1'b1, 1'b1, brk_m, ext_m, (c == 8'h29) && !brk_m && !ext_m, 2'b00};
      brk_m = 1'b0;
      ext_m = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input bit is_parity);
    ev_t e;
    e.flags = is_parity ? 7'b0000010 : 7'b0000001;
    e.code  = 8'h00;
    brk_m   = 1'b0;
    ext_m   = 1'b0;
    exp_q.push_back(e);
  endtask

  // bits[0] is the start bit; data changes while the PS/2 clock is high
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      ps2_data = bits[i];
      repeat (HALF) @(posedge clock);
      #1;
      ps2_clock = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(posedge clock);
      #1;
      ps2_clock = 1'b1;
      if (i == 0) check("busy after start bit", {31'b0, busy}, 32'd1);
    end
    @(posedge clock); #1;
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clock);
    #1;
  endtask

  task automatic frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    logic par;
    logic [10:0] bits;
    par  = ~^c ^ bad_par;
    bits = {~bad_stop, par, c, 1'b0};
    if (bad_par) expect_err(1'b1);
    else if (bad_stop) expect_err(1'b0);
    else expect_good(c);
    send_bits(bits, 11);
  endtask

  // Send a frame and pin the observed event against hand-computed literals
  task automatic frame_lit(input string name, input logic [7:0] c, input bit bad_par,
                           input logic [6:0] lit_flags, input logic [7:0] lit_code);
    int base;
    base = ev_cnt;
    frame(c, bad_par, 1'b0);
    check({name, " event count"}, ev_cnt - base, 32'd1);
    check({name, " flags"}, {25'b0, cap}, {25'b0, lit_flags});
    check({name, " scan_code"}, {24'b0, scan_code}, {24'b0, lit_code});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int d;
    bit seen_busy;
    brk_m    = 1'b0;
    ext_m    = 1'b0;
    exp_code = 8'h00;
    cap      = '0;
    cap_code = '0;
    cap_cyc  = 0;

    // Compare process: every cycle, outputs must match the model
    fork
      forever begin
        @(negedge clock);
        if (reset) begin
          exp_code = 8'h00;
        end else if (scan_valid | key_event | parity_err | frame_err) begin
          cap      = {scan_valid, key_event, key_break, key_extended, flap, parity_err, frame_err};
          cap_code = scan_code;
          cap_cyc  = cyc;
          ev_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected event", {25'b0, cap}, 32'd0);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.flags[6]) exp_code = e.code;
            check("event flags", {25'b0, cap}, {25'b0, e.flags});
            check("event scan_code", {24'b0, scan_code}, {24'b0, exp_code});
          end
        end else begin
          check("quiet outputs", {21'b0, key_break, key_extended, flap, scan_code},
                {24'b0, exp_code});
        end
      end
    join_none

    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset scan_code", {24'b0, scan_code}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset pulses",
          {25'b0, scan_valid, key_event, key_break, key_extended, flap, parity_err, frame_err},
          32'h0);
    repeat (20) @(posedge clock);

    frame_lit("space make", 8'h29, 1'b0, 7'b1100100, 8'h29);
    frame_lit("break prefix", 8'hF0, 1'b0, 7'b1000000, 8'hF0);
    frame_lit("space break", 8'h29, 1'b0, 7'b1110000, 8'h29);
    frame_lit("space again", 8'h29, 1'b0, 7'b1100100, 8'h29);
    frame_lit("ext prefix", 8'hE0, 1'b0, 7'b1000000, 8'hE0);
    frame_lit("ext 0x75", 8'h75, 1'b0, 7'b1101000, 8'h75);
    frame_lit("bad parity", 8'h29, 1'b1, 7'b0000010, 8'h75);
    frame_lit("break after perr", 8'hF0, 1'b0, 7'b1000000, 8'hF0);
    frame_lit("space break 2", 8'h29, 1'b0, 7'b1110000, 8'h29);
    frame_lit("ext before perr", 8'hE0, 1'b0, 7'b1000000, 8'hE0);
    frame_lit("perr clears ext", 8'h29, 1'b1, 7'b0000010, 8'hE0);
    frame_lit("plain after perr", 8'h29, 1'b0, 7'b1100100, 8'h29);

    // Bad stop bit
    base = ev_cnt;
    frame(8'h1C, 1'b0, 1'b1);
    check("bad stop count", ev_cnt - base, 32'd1);
    check("bad stop flags", {25'b0, cap}, 32'b0000001);

    // Short clock glitch while idle must not start a frame
    base = ev_cnt;
    @(posedge clock); #1;
    ps2_clock = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    ps2_clock = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (busy) seen_busy = 1'b1;
    end
    check("glitch busy", {31'b0, seen_busy}, 32'd0);
    check("glitch events", ev_cnt - base, 32'd0);

    // Start + 5 data bits then silence: timeout
    base = ev_cnt;
    expect_err(1'b0);
    send_bits({2'b11, 8'h15, 1'b0}, 6);
    for (int i = 0; i < 2 * TO && ev_cnt == base; i++) @(posedge clock);
    #1;
    check("timeout count", ev_cnt - base, 32'd1);
    check("timeout flags", {25'b0, cap}, 32'b0000001);
    d = cap_cyc - last_fall;
    check("timeout latency window", {31'b0, (d >= int'(TO + FL)) && (d <= int'(TO + FL + 6))},
          32'd1);
    check("timeout busy", {31'b0, busy}, 32'd0);

    // Reset after 4 bits of a frame, then a clean 0x1C
    base = ev_cnt;
    send_bits({2'b11, 8'h1C, 1'b0}, 4);
    @(posedge clock); #1;
    reset = 1'b1;
    brk_m = 1'b0;
    ext_m = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (200) @(posedge clock);
    #1;
    check("abort events", ev_cnt - base, 32'd0);
    check("abort scan_code", {24'b0, scan_code}, 32'h0);
    check("abort busy", {31'b0, busy}, 32'd0);
    frame_lit("after abort", 8'h1C, 1'b0, 7'b1100000, 8'h1C);

    repeat (50) @(posedge clock);
    #1;
    check("model queue drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
